// File: rtl/rc4_key_dispatch.sv
// Interleaved key-space dispatcher for NUM_CORES RC4 decrypt cores.
// Core i walks keys i, i+NUM_CORES, ... up to KEY_MAX; first hit (lowest index) wins.
module rc4_key_dispatch #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF,
    parameter int                   CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           stop_req,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_start,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_hit,
    output logic                           stop,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [CW-1:0]                  found_core
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        FOUND,
        EXHAUSTED,
        ABORTED
    } state_t;

    state_t                         state;
    logic [NUM_CORES-1:0]           retired;
    logic [NUM_CORES-1:0]           launch_retire;
    logic [NUM_CORES-1:0]           hit_vec;
    logic [NUM_CORES-1:0]           done_vec;
    logic [NUM_CORES-1:0]           retire_now;
    logic [NUM_CORES-1:0]           advance;
    logic [KEY_WIDTH:0]             step_sum [NUM_CORES];
    logic [NUM_CORES*KEY_WIDTH-1:0] next_key;
    logic [CW-1:0]                  win_idx;
    logic [KEY_WIDTH-1:0]           win_key;
    logic                           any_hit;
    logic                           all_retired;

    // One extra bit keeps the stride addition from wrapping past KEY_MAX.
    function automatic logic [KEY_WIDTH:0] key_step(input logic [KEY_WIDTH-1:0] k);
        return {1'b0, k} + (KEY_WIDTH+1)'(NUM_CORES);
    endfunction

    function automatic logic key_over(input logic [KEY_WIDTH:0] k);
        return k > {1'b0, KEY_MAX};
    endfunction

    always_comb begin
        hit_vec       = core_done & core_hit & ~retired;
        done_vec      = core_done & ~core_hit & ~retired;
        retire_now    = '0;
        advance       = '0;
        next_key      = '0;
        launch_retire = '0;
        win_idx       = '0;
        win_key       = '0;
        any_hit       = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            step_sum[i]      = key_step(core_key[i*KEY_WIDTH +: KEY_WIDTH]);
            launch_retire[i] = key_over((KEY_WIDTH+1)'(i));
            retire_now[i]    = done_vec[i] & key_over(step_sum[i]);
            advance[i]       = done_vec[i] & ~key_over(step_sum[i]);
            next_key[i*KEY_WIDTH +: KEY_WIDTH] = step_sum[i][KEY_WIDTH-1:0];
        end
        // Descending scan so the lowest hitting index is the one that sticks.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                win_idx = CW'(i);
                win_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
        all_retired = &(retired | retire_now);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state      <= IDLE;
            core_key   <= '0;
            core_start <= '0;
            retired    <= '0;
            stop       <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            found_core <= '0;
        end else begin
            core_start <= '0;
            case (state)
                IDLE, FOUND, EXHAUSTED, ABORTED: begin
                    if (start) begin
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        stop       <= 1'b0;
                        busy       <= 1'b0;
                        found_key  <= '0;
                        found_core <= '0;
                        for (int i = 0; i < NUM_CORES; i++)
                            core_key[i*KEY_WIDTH +: KEY_WIDTH] <= KEY_WIDTH'(i);
                        retired    <= launch_retire;
                        // First pulses are high during LAUNCH alongside the fresh keys.
                        core_start <= ~launch_retire;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (&retired) begin
                        exhausted <= 1'b1;
                        stop      <= 1'b1;
                        state     <= EXHAUSTED;
                    end else begin
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (any_hit) begin
                        found      <= 1'b1;
                        found_key  <= win_key;
                        found_core <= win_idx;
                        stop       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FOUND;
                    end else begin
                        retired <= retired | retire_now;
                        for (int i = 0; i < NUM_CORES; i++)
                            if (advance[i])
                                core_key[i*KEY_WIDTH +: KEY_WIDTH] <= next_key[i*KEY_WIDTH +: KEY_WIDTH];
                        if (all_retired) begin
                            exhausted <= 1'b1;
                            stop      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= EXHAUSTED;
                        end else if (stop_req) begin
                            stop  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ABORTED;
                        end else begin
                            core_start <= advance;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_dispatch.sv
// Scoreboard bench: expected (core, key) launches are queued as stimulus is driven
// and popped when core_start pulses appear; a second instance runs a KEY_MAX=10 exhaust.
module tb_rc4_key_dispatch;

    logic        clk = 1'b0;
    logic        reset_n, start, stop_req;
    logic [95:0] core_key;
    logic [3:0]  core_start, core_done, core_hit;
    logic        stop, busy, found, exhausted;
    logic [23:0] found_key;
    logic [1:0]  found_core;

    logic        start2, stop_req2;
    logic [95:0] core_key2;
    logic [3:0]  core_start2, core_done2, core_hit2;
    logic        stop2, busy2, found2, exhausted2;
    logic [23:0] found_key2;
    logic [1:0]  found_core2;

    typedef struct {
        int          core;
        logic [23:0] key;
    } exp_t;

    exp_t        q[$];
    exp_t        q2[$];
    logic [23:0] mk [4];
    logic [23:0] mk2 [4];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          issued   = 0;

    always #5 clk = ~clk;

    rc4_key_dispatch #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'h3FFFFF)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start), .stop_req(stop_req),
        .core_key(core_key), .core_start(core_start), .core_done(core_done),
        .core_hit(core_hit), .stop(stop), .busy(busy), .found(found),
        .exhausted(exhausted), .found_key(found_key), .found_core(found_core)
    );

    rc4_key_dispatch #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'd10)) dut2 (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start2), .stop_req(stop_req2),
        .core_key(core_key2), .core_start(core_start2), .core_done(core_done2),
        .core_hit(core_hit2), .stop(stop2), .busy(busy2), .found(found2),
        .exhausted(exhausted2), .found_key(found_key2), .found_core(found_core2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] kslice(input logic [95:0] v, input int i);
        return 32'(v[i*24 +: 24]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_launch();
        for (int i = 0; i < 4; i++) begin
            mk[i] = 24'(i);
            q.push_back('{core: i, key: 24'(i)});
        end
    endtask

    task automatic push_done(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) begin
                mk[i] = mk[i] + 24'd4;
                q.push_back('{core: i, key: mk[i]});
            end
    endtask

    // Scoreboard for the main instance: every pulse must match a queued launch.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++)
            if (core_start[i] === 1'b1) begin
                if (q.size() == 0) begin
                    check("start_unexpected", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("start_core", 32'(i), 32'(e.core));
                    check("start_key", kslice(core_key, i), 32'(e.key));
                end
            end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] pend;
        int         hit_at;
        reset_n = 1'b0; start = 1'b0; stop_req = 1'b0; core_done = '0; core_hit = '0;
        start2 = 1'b0; stop_req2 = 1'b0; core_done2 = '0; core_hit2 = '0;
        tick(); tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_stop", 32'(stop), 0);
        check("rst_found", 32'(found), 0);
        check("rst_keys", 32'(|core_key), 0);
        reset_n = 1'b1;
        tick();

        // Launch
        push_launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("launch_start", 32'(core_start), 32'hF);
        for (int i = 0; i < 4; i++) check("launch_key", kslice(core_key, i), 32'(i));
        tick();
        check("launch_busy", 32'(busy), 1);
        check("launch_pulse_len", 32'(core_start), 0);

        // Single advance of core 2
        core_done = 4'b0100;
        push_done(4'b0100);
        tick();
        core_done = '0;
        check("adv_start", 32'(core_start), 32'h4);
        check("adv_key2", kslice(core_key, 2), 6);
        check("adv_key0", kslice(core_key, 0), 0);
        check("adv_key1", kslice(core_key, 1), 1);
        check("adv_key3", kslice(core_key, 3), 3);
        tick();

        // Walk cores 1 and 3 to keys 0x1D / 0x1F
        for (int n = 0; n < 7; n++) begin
            core_done = 4'b1010;
            push_done(4'b1010);
            tick();
            core_done = '0;
        end
        tick();
        check("pre_hit_key1", kslice(core_key, 1), 32'h1D);
        check("pre_hit_key3", kslice(core_key, 3), 32'h1F);

        // Simultaneous hit: lowest index wins
        core_done = 4'b1010;
        core_hit  = 4'b1010;
        tick();
        core_done = '0;
        core_hit  = '0;
        check("hit_found", 32'(found), 1);
        check("hit_core", 32'(found_core), 1);
        check("hit_key", 32'(found_key), 32'h1D);
        check("hit_stop", 32'(stop), 1);
        check("hit_busy", 32'(busy), 0);
        check("hit_no_start", 32'(core_start), 0);
        core_done = 4'b1111;
        tick();
        core_done = '0;
        tick(); tick();
        check("found_hold", 32'(found), 1);
        check("found_stop_hold", 32'(stop), 1);
        check("found_no_start", 32'(core_start), 0);

        // Restart from FOUND, advance, abort, restart again
        push_launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_found_clr", 32'(found), 0);
        check("rs_stop_clr", 32'(stop), 0);
        check("rs_key_clr", 32'(found_key), 0);
        check("rs_start", 32'(core_start), 32'hF);
        tick();
        check("rs_busy", 32'(busy), 1);
        core_done = 4'b0001;
        push_done(4'b0001);
        tick();
        core_done = '0;
        check("rs_adv_key0", kslice(core_key, 0), 4);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", 32'(core_start), 0);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        check("abort_stop", 32'(stop), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_found", 32'(found), 0);
        check("abort_exh", 32'(exhausted), 0);
        tick();
        check("abort_stop_hold", 32'(stop), 1);
        push_launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("re_stop_clr", 32'(stop), 0);
        for (int i = 0; i < 4; i++) check("re_key", kslice(core_key, i), 32'(i));
        tick();
        check("re_busy", 32'(busy), 1);

        // Reset mid-RUN while a done would have produced a start pulse
        core_done = 4'b0001;
        reset_n = 1'b0;
        tick();
        core_done = '0;
        tick(); tick();
        check("mrst_start", 32'(core_start), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_stop", 32'(stop), 0);
        check("mrst_keys", 32'(|core_key), 0);
        check("mrst_found", 32'(found), 0);
        reset_n = 1'b1;
        core_done = 4'b1111;
        tick();
        core_done = '0;
        tick(); tick();
        check("idle_done_ignored", 32'(core_start), 0);
        check("idle_busy", 32'(busy), 0);
        check("main_queue_empty", 32'(q.size()), 0);

        // Exhaustion on KEY_MAX=10: cores ack every start one cycle later, no hits
        for (int i = 0; i < 4; i++) begin
            mk2[i] = 24'(i);
            q2.push_back('{core: i, key: 24'(i)});
        end
        start2 = 1'b1;
        pend   = '0;
        hit_at = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            start2 = 1'b0;
            if (exhausted2) begin
                hit_at = cyc;
                break;
            end
            for (int i = 0; i < 4; i++)
                if (core_start2[i]) begin
                    int idx;
                    idx = -1;
                    issued++;
                    for (int k = 0; k < q2.size(); k++)
                        if (idx < 0 && q2[k].core == i) idx = k;
                    if (idx < 0) check("x_start_unexpected", 32'(i), 32'hFFFF_FFFF);
                    else begin
                        check("x_start_key", kslice(core_key2, i), 32'(q2[idx].key));
                        q2.delete(idx);
                    end
                end
            core_done2 = pend;
            for (int i = 0; i < 4; i++)
                if (pend[i]) begin
                    mk2[i] = mk2[i] + 24'd4;
                    if (mk2[i] <= 24'd10) q2.push_back('{core: i, key: mk2[i]});
                end
            pend = core_start2;
        end
        core_done2 = '0;
        check("x_reached", 32'(hit_at >= 0), 1);
        check("x_exhausted", 32'(exhausted2), 1);
        check("x_stop", 32'(stop2), 1);
        check("x_busy", 32'(busy2), 0);
        check("x_found", 32'(found2), 0);
        check("x_issued", 32'(issued), 11);
        check("x_queue_empty", 32'(q2.size()), 0);
        tick(); tick();
        check("x_hold", 32'(exhausted2), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rc4_key_dispatch.md
Name: rc4_key_dispatch

Overview:
- Parametrised key-space dispatcher for the multi-core RC4 brute-force search; it generalises the single-core/fixed-pair search control to NUM_CORES decrypt cores.
- Core i is assigned the interleaved key sequence i, i+NUM_CORES, i+2*NUM_CORES, ... up to KEY_MAX.
- The block hands out keys through a start/done handshake, retires cores whose range is exhausted, arbitrates simultaneous hits, and broadcasts stop.
- Sits between the top-level search control (start/abort, HEX/LEDR display) and the array of per-core decrypt FSMs.

Parameters:
- NUM_CORES, 4, number of decrypt cores served (1..16).
- KEY_WIDTH, 24, width of one secret key.
- KEY_MAX, 24'h3FFFFF, highest key searched (upper 2 key bits fixed at 0).
- CW, (NUM_CORES>1 ? $clog2(NUM_CORES) : 1), width of the core index.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the CLOCK_50 rising edge.
- start  in  1  one-cycle pulse; begins a new search.
- stop_req  in  1  level; aborts a running search.
- core_key  out  NUM_CORES*KEY_WIDTH  key for core i in bits [i*KEY_WIDTH +: KEY_WIDTH].
- core_start  out  NUM_CORES  one-cycle pulse per core; core_key slice is valid while it is high.
- core_done  in  NUM_CORES  one-cycle pulse per core; the core finished its current key.
- core_hit  in  NUM_CORES  qualified by core_done[i]; 1 = plaintext valid for that key.
- stop  out  1  broadcast halt to all cores.
- busy  out  1  high in RUN.
- found  out  1  key located.
- exhausted  out  1  all keys tried, no hit.
- found_key  out  KEY_WIDTH  winning key.
- found_core  out  CW  index of the winning core.

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; every output 0; all core_key slices 0; all retired flags cleared. Reset applies in any state, including mid-search, and cancels any pending core_start.
- States: IDLE, LAUNCH, RUN, FOUND, EXHAUSTED, ABORTED.
- IDLE, or any of FOUND / EXHAUSTED / ABORTED, on start:
  - clear found, exhausted, found_key, found_core and stop;
  - load key_i = i for every core;
  - retire core i if i > KEY_MAX;
  - go to LAUNCH.
- LAUNCH (1 cycle):
  - core_start[i]=1 for every non-retired core;
  - go to RUN and assert busy;
  - if every core is retired, go straight to EXHAUSTED instead.
- RUN, per core i with core_done[i]=1 and core_hit[i]=0:
  - compute key_i + NUM_CORES in KEY_WIDTH+1 bits, so no wrap-around occurs;
  - if the result is > KEY_MAX, set retired[i] and leave core_key unchanged;
  - otherwise store the result and pulse core_start[i] on the next cycle.
  - Latency from done to the next start is exactly 1 cycle.
  - Multiple cores may complete in the same cycle; each is serviced independently in that cycle.
- RUN, any core_done[i] & core_hit[i]:
  - go to FOUND; latch found_key = key_i and found_core = i;
  - if several hit in the same cycle, the lowest index wins;
  - found=1, stop=1, busy=0; suppress all core_start pulses.
- RUN, all cores retired (including retirement in the current cycle) and no hit: go to EXHAUSTED; exhausted=1, stop=1, busy=0.
- RUN, stop_req=1 with no hit in the same cycle: go to ABORTED; stop=1, busy=0, found=exhausted=0.
- Priority within one cycle: hit > exhaustion > stop_req.
- FOUND, EXHAUSTED and ABORTED hold all outputs until start or reset.
- start while in LAUNCH or RUN is ignored.
- core_done from a retired core, or in any state other than RUN, is ignored.
- core_hit without core_done is ignored.
- stop is held high continuously in FOUND, EXHAUSTED and ABORTED.

Test Plan:
- Reset: hold reset_n=0 for 3 edges mid-RUN -> all outputs 0, state IDLE, and no core_start pulse follows.
- Launch (NUM_CORES=4): pulse start -> core_start=4'b1111 exactly 1 cycle later; core_key slices = 0,1,2,3; busy=1.
- Advance: core_done[2]=1, hit=0 -> one cycle later core_start=4'b0100 and core_key[2]=6; other slices unchanged.
- Hit tie: with cores 1 and 3 holding keys 0x00001D and 0x00001F, pulse done+hit on both in the same cycle -> found=1, found_core=1, found_key=0x00001D, stop=1, no further core_start.
- Exhaust (KEY_MAX=10, NUM_CORES=4):
  - auto-ack every start without hit -> core 0 retires after key 8, cores 1/2 after 9/10, core 3 after 7;
  - exhausted=1 and stop=1 once the last core retires; exactly 11 distinct keys are issued.
- Abort and restart: stop_req=1 in RUN -> ABORTED, stop=1, found=0, exhausted=0; a later start -> flags clear and keys reload to 0..3.
